// File: rtl/lfsr_seq_checker.sv
// Self-checking monitor for a Galois LFSR state bus: predicts each next state,
// flags mismatches and all-zero lock-up, and measures the sequence period.
// Optional mismatch event counter: define LFSR_CHK_ERRCNT_EN.
module lfsr_seq_checker #(
    parameter int unsigned    W    = 3,
    parameter logic [W-1:0]   TAPS = 3'b110
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    input  logic [W-1:0] lfsr_in,
    input  logic         load,
    output logic         in_sync,
    output logic         err,
    output logic         lockup,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic [7:0]   err_cnt
);

    // state  | meaning
    // IDLE   | checker disabled, nothing sampled
    // SYNC   | current sample becomes the seed and first reference
    // TRACK  | each sample compared against the Galois step of the previous
    // FAULT  | prediction mismatch seen, held until load or disable
    // LOCKUP | all-zero state seen, held until load or disable
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        TRACK  = 3'd2,
        FAULT  = 3'd3,
        LOCKUP = 3'd4
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] seed_q, seed_d;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         period_valid_q, period_valid_d;
    logic         err_q, err_d;
    logic         lockup_q, lockup_d;
    logic         in_sync_q, in_sync_d;

    function automatic logic [W-1:0] galois_step(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q        <= IDLE;
            seed_q         <= '0;
            prev_q         <= '0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            err_q          <= 1'b0;
            lockup_q       <= 1'b0;
            in_sync_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            err_q          <= err_d;
            lockup_q       <= lockup_d;
            in_sync_q      <= in_sync_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        prev_d         = prev_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_d          = err_q;
        lockup_d       = lockup_q;
        in_sync_d      = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else if (load) begin
            // The sample seen alongside load is the pre-seed state; skip it.
            state_d  = SYNC;
            err_d    = 1'b0;
            lockup_d = 1'b0;
        end else if (lfsr_in == '0 &&
                     (state_q == SYNC || state_q == TRACK || state_q == FAULT)) begin
            state_d  = LOCKUP;
            lockup_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SYNC;
                end
                SYNC: begin
                    seed_d  = lfsr_in;
                    prev_d  = lfsr_in;
                    cnt_d   = ONE;
                    state_d = TRACK;
                end
                TRACK: begin
                    prev_d = lfsr_in;
                    if (lfsr_in != galois_step(prev_q)) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end else if (lfsr_in == seed_q) begin
                        period_d       = cnt_q;
                        period_valid_d = 1'b1;
                        cnt_d          = ONE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                FAULT:   state_d = FAULT;
                LOCKUP:  state_d = LOCKUP;
                default: state_d = IDLE;
            endcase
        end

        in_sync_d = (state_d == TRACK);
    end

    assign in_sync      = in_sync_q;
    assign err          = err_q;
    assign lockup       = lockup_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

`ifdef LFSR_CHK_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == TRACK && state_d == FAULT && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Cleared only by reset so a debug session can count across reloads.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus random upstream traffic,
// compared each cycle against a behavioural model of the checker.
module tb_lfsr_seq_checker;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         arst;
    logic         en;
    logic [W-1:0] lfsr_in;
    logic         load;
    logic         in_sync;
    logic         err;
    logic         lockup;
    logic [W-1:0] period;
    logic         period_valid;
    logic [7:0]   err_cnt;

    lfsr_seq_checker #(.W(W), .TAPS(3'b110)) dut (
        .clk          (clk),
        .arst         (arst),
        .en           (en),
        .lfsr_in      (lfsr_in),
        .load         (load),
        .in_sync      (in_sync),
        .err          (err),
        .lockup       (lockup),
        .period       (period),
        .period_valid (period_valid),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: mode names rather than encoding; period from sample timestamps.
    localparam int M_IDLE = 0, M_SYNC = 1, M_TRACK = 2, M_FAULT = 3, M_LOCK = 4;
    int       m_mode;
    int       m_seed, m_prev, m_seed_t;
    int       m_period, m_errcnt;
    bit       m_pv, m_err, m_lock;
    logic [2:0] up;

    function automatic int gal(input int s);
        return (s / 2) ^ ((s % 2 == 1) ? 6 : 0);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h exp %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_seed = 0; m_prev = 0; m_seed_t = 0;
        m_period = 0; m_errcnt = 0; m_pv = 0; m_err = 0; m_lock = 0;
    endtask

    task automatic model_update(input bit e, input bit l, input int v);
        m_pv = 0;
        if (!e) begin
            m_mode = M_IDLE;
        end else if (l) begin
            m_mode = M_SYNC; m_err = 0; m_lock = 0;
        end else if (v == 0 && (m_mode == M_SYNC || m_mode == M_TRACK || m_mode == M_FAULT)) begin
            m_mode = M_LOCK; m_lock = 1;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SYNC;
        end else if (m_mode == M_SYNC) begin
            m_seed = v; m_prev = v; m_seed_t = cyc; m_mode = M_TRACK;
        end else if (m_mode == M_TRACK) begin
            if (v != gal(m_prev)) begin
                m_mode = M_FAULT; m_err = 1;
`ifdef LFSR_CHK_ERRCNT_EN
                if (m_errcnt < 255) m_errcnt++;
`endif
            end else if (v == m_seed) begin
                m_period = (cyc - m_seed_t > 7) ? 7 : cyc - m_seed_t;
                m_pv = 1; m_seed_t = cyc;
            end
            m_prev = v;
        end
    endtask

    task automatic compare_all();
        check_val("in_sync",      in_sync,      (m_mode == M_TRACK));
        check_val("err",          err,          m_err);
        check_val("lockup",       lockup,       m_lock);
        check_val("period",       period,       m_period);
        check_val("period_valid", period_valid, m_pv);
        check_val("err_cnt",      err_cnt,      m_errcnt);
    endtask

    task automatic drive(input bit e, input bit l, input logic [2:0] v);
        en = e; load = l; lfsr_in = v;
        @(posedge clk);
        cyc++;
        model_update(e, l, int'(v));
        #1;
        compare_all();
    endtask

    task automatic run_valid(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, up);
            up = 3'(gal(int'(up)));
        end
    endtask

    task automatic load_seed(input logic [2:0] s);
        drive(1'b1, 1'b1, up);
        up = s;
    endtask

    function automatic logic [2:0] wrong_of(input logic [2:0] g);
        return (g == 3'b001) ? 3'b010 : 3'b001;
    endfunction

    task automatic inject_fault();
        logic [2:0] s;
        s = 3'($urandom_range(1, 7));
        load_seed(s);
        drive(1'b1, 1'b0, up);
        up = 3'(gal(int'(up)));
        drive(1'b1, 1'b0, wrong_of(up));
        up = 3'(gal(int'(up)));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp3;
        arst = 1'b1; en = 1'b0; load = 1'b0; lfsr_in = '0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk) arst = 1'b0;

        // golden sequence from 001
        up = 3'b001;
        run_valid(22);
        check_val("golden_period", period, 7);
        check_val("golden_in_sync", in_sync, 1);

        // mismatch: 010 in place of 011
        for (int i = 0; i < 8 && up != 3'b011; i++) run_valid(1);
        drive(1'b1, 1'b0, 3'b010);
        up = 3'(gal(int'(3'b011)));
        check_val("fault_err", err, 1);
        check_val("fault_in_sync", in_sync, 0);
        run_valid(20);
        check_val("fault_sticky", err, 1);

        // recover with seed 111
        load_seed(3'b111);
        run_valid(9);
        check_val("reload_err", err, 0);
        check_val("reload_period", period, 7);

        // lock-up on all-zero
        drive(1'b1, 1'b0, 3'b000);
        check_val("lockup_set", lockup, 1);
        check_val("lockup_err", err, 0);
        run_valid(5);
        check_val("lockup_hold", lockup, 1);
        load_seed(3'b001);
        run_valid(10);

        // asynchronous reset mid-TRACK
        #1 arst = 1'b1;
        #2;
        model_reset();
        check_val("arst_in_sync", in_sync, 0);
        check_val("arst_err", err, 0);
        check_val("arst_lockup", lockup, 0);
        check_val("arst_period", period, 0);
        check_val("arst_pv", period_valid, 0);
        #1 arst = 1'b0;
        run_valid(12);
        check_val("arst_resync", in_sync, 1);

        // error counter: 3 events, then saturation
        for (int i = 0; i < 3; i++) inject_fault();
`ifdef LFSR_CHK_ERRCNT_EN
        exp3 = 3;
`else
        exp3 = 0;
`endif
        check_val("errcnt_3", err_cnt, exp3);
        for (int i = 0; i < 297; i++) inject_fault();
`ifdef LFSR_CHK_ERRCNT_EN
        check_val("errcnt_sat", err_cnt, 255);
`else
        check_val("errcnt_off", err_cnt, 0);
`endif

        // randomized upstream traffic
        load_seed(3'($urandom_range(1, 7)));
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                load_seed(3'($urandom_range(1, 7)));
            end else if (r < 9) begin
                drive(1'b1, 1'b0, up ^ 3'($urandom_range(1, 7)));
                up = 3'(gal(int'(up)));
            end else if (r < 11) begin
                drive(1'b1, 1'b0, 3'b000);
                up = 3'(gal(int'(up)));
            end else if (r < 13) begin
                drive(1'b0, 1'($urandom_range(0, 1)), up);
                up = 3'(gal(int'(up)));
            end else begin
                run_valid(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Sits directly downstream of the muxed Galois LFSR. Samples its state bus every clock.
- Predicts the next Galois state from the previous sample and flags any mismatch.
- Detects the all-zero lock-up state and measures the sequence period.
- Gives the verification and debug path a self-checking monitor for the LFSR, including after seed loads.

Parameters:
- W, 3, LFSR width in bits.
- TAPS, 3'b110, Galois feedback mask (x^3+x^2+1, maximal length 7 for W=3).

Ports:
- clk  input  1  system clock, rising edge.
- arst  input  1  asynchronous, active-high reset.
- en  input  1  checker enable.
- lfsr_in  input  W  LFSR state from the upstream stage.
- load  input  1  copy of the upstream seed-load strobe (L); the upstream state changes to its seed on the next edge.
- in_sync  output  1  high while state is TRACK.
- err  output  1  sticky prediction-mismatch flag.
- lockup  output  1  sticky all-zero flag.
- period  output  W  last measured period in clocks.
- period_valid  output  1  one-cycle pulse when period updates.
- err_cnt  output  8  mismatch event count (see Optional Feature).

Behaviour:
- All state and outputs are registered. On arst high, immediately (asynchronously): state=IDLE, all outputs 0, seed/prev/cnt = 0.
- Galois step: step(s) = (s >> 1) ^ (s[0] ? TAPS : 0).
- States: IDLE, SYNC, TRACK, FAULT, LOCKUP.
- Transitions, evaluated each edge in priority order:
  1. en=0: IDLE from any state.
  2. load=1: SYNC from any state. err and lockup clear, and the next sample is not compared.
  3. lfsr_in=0 in SYNC/TRACK/FAULT: LOCKUP, lockup<=1.
  4. State-specific rules below.
- IDLE: if en=1, go to SYNC.
- SYNC: seed<=lfsr_in, prev<=lfsr_in, cnt<=1, go to TRACK.
- TRACK:
  - If lfsr_in != step(prev): go to FAULT, err<=1, in_sync<=0.
  - Else if lfsr_in == seed: period<=cnt, period_valid<=1 for one cycle, cnt<=1.
  - Else: cnt<=cnt+1, saturating at all-ones.
  - In all cases prev<=lfsr_in.
- FAULT: holds; err stays 1. Exits only via load, en=0 or arst.
- LOCKUP: holds; lockup stays 1. Exits only via load, en=0 or arst.
- Latency: err/lockup/period_valid assert on the edge after the offending or closing sample is presented, i.e. visible one clock after the sample.
- period holds its last value until the next update. It is not cleared by load.
- load and a mismatch in the same cycle: load wins, err is not set.
- arst mid-TRACK: outputs drop to 0 without waiting for clk.

Optional Feature:
- Macro LFSR_CHK_ERRCNT_EN.
- Defined: err_cnt increments by 1 on each TRACK->FAULT transition and saturates at 255. It is cleared only by arst, not by load.
- Undefined: err_cnt is tied to 8'd0 and the counter logic is absent. The port remains so the interface is identical.

Test Plan:
- Reset, en=1, drive the golden sequence 001,110,011,111,101,100,010,001,... each clock -> in_sync=1 one clock after SYNC; period=7 with period_valid pulsing every 7 clocks; err=0, lockup=0.
- In TRACK, replace expected 011 with 010 -> err=1 and in_sync=0 the next clock; err stays 1 for 20 further clocks of valid data.
- From FAULT, pulse load=1 for one clock, then drive the sequence from seed 111 (111,101,100,010,001,110,011,111) -> err clears; in_sync=1 after SYNC; period=7 when 111 recurs.
- Drive lfsr_in=000 during TRACK -> lockup=1 next clock; err stays 0; state remains LOCKUP until load.
- Assert arst for 3 ns mid-TRACK between clock edges -> in_sync, err, lockup, period, period_valid all 0 before the next edge; after release with en=1, resync occurs via IDLE->SYNC.
- With LFSR_CHK_ERRCNT_EN defined, inject 3 mismatches separated by load pulses -> err_cnt=3. Force 300 fault/load cycles -> err_cnt saturates at 255. Without the macro -> err_cnt=0 throughout.
